// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline sequencer and the core's stage logic.
// The core side is the master; pipe_ctrl is the slave.
interface pipe_ctrl_if #(
  parameter int PERF_W = 32
);
  logic              stallreq_id;
  logic              mc_start;
  logic              mc_cancel;
  logic              excp_req;
  logic [31:0]       excp_pc;
  logic [5:0]        stall;
  logic              flush;
  logic [31:0]       new_pc;
  logic              mc_done;
  logic              busy;
  logic [PERF_W-1:0] stall_cycles;

  modport master (
    output stallreq_id, mc_start, mc_cancel, excp_req, excp_pc,
    input  stall, flush, new_pc, mc_done, busy, stall_cycles
  );

  modport slave (
    input  stallreq_id, mc_start, mc_cancel, excp_req, excp_pc,
    output stall, flush, new_pc, mc_done, busy, stall_cycles
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges decode/multi-cycle stalls with exception flushes
// and counts stalled cycles. Control outputs are combinational off the state.
module pipe_ctrl #(
  parameter int MC_CYCLES = 32,
  parameter int PERF_W    = 32
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);
  localparam int TW = $clog2(MC_CYCLES + 1);
  localparam logic [TW-1:0] LAST    = TW'(MC_CYCLES - 1);
  localparam logic [5:0]   STALL_MC = 6'b001111;
  localparam logic [5:0]   STALL_ID = 6'b000111;

  typedef enum logic [1:0] {IDLE, MC_BUSY, MC_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [TW-1:0]     r_timer, w_timer_nxt;
  logic [PERF_W-1:0] r_stall_cycles;
  logic [5:0]        w_stall;
  logic              w_flush;
  logic              w_mc_done;
  logic [31:0]       w_new_pc;
  logic [5:0]        w_stall_id;

  assign w_stall_id = bus.stallreq_id ? STALL_ID : 6'b000000;

  always_comb begin
    w_stall     = '0;
    w_flush     = 1'b0;
    w_new_pc    = '0;
    w_mc_done   = 1'b0;
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    if (rst) begin
      w_state_nxt = IDLE;
      w_timer_nxt = '0;
    end else if (bus.excp_req) begin
      w_flush     = 1'b1;
      w_new_pc    = bus.excp_pc;
      w_state_nxt = IDLE;
      w_timer_nxt = '0;
    end else if (bus.mc_cancel && (r_state != IDLE)) begin
      w_stall     = w_stall_id;
      w_state_nxt = IDLE;
      w_timer_nxt = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.mc_start) begin
            // The issue cycle counts as stall cycle 0; MC_BUSY covers 1..MC_CYCLES-1.
            w_stall     = STALL_MC;
            w_state_nxt = MC_BUSY;
            w_timer_nxt = TW'(1);
          end else begin
            w_stall = w_stall_id;
          end
        end
        MC_BUSY: begin
          w_stall = STALL_MC;
          if (r_timer >= LAST) begin
            w_state_nxt = MC_DONE;
            w_timer_nxt = '0;
          end else begin
            w_timer_nxt = r_timer + TW'(1);
          end
        end
        MC_DONE: begin
          w_mc_done   = 1'b1;
          w_stall     = w_stall_id;
          w_state_nxt = IDLE;
        end
        default: begin
          w_state_nxt = IDLE;
          w_timer_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    r_state <= w_state_nxt;
    r_timer <= w_timer_nxt;
    if (rst)
      r_stall_cycles <= '0;
    else if (w_stall[0] && (r_stall_cycles != {PERF_W{1'b1}}))
      r_stall_cycles <= r_stall_cycles + PERF_W'(1);
  end

  assign bus.stall        = w_stall;
  assign bus.flush        = w_flush;
  assign bus.new_pc       = w_new_pc;
  assign bus.mc_done      = w_mc_done;
  assign bus.busy         = !rst && (r_state != IDLE);
  assign bus.stall_cycles = r_stall_cycles;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios with literal expectations plus a
// randomized run checked every cycle against an op-age reference model.
module tb_pipe_ctrl;
  localparam int MC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sreq = 1'b0, start = 1'b0, cancel = 1'b0, excp = 1'b0;
  logic [31:0] pc = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl_if #(.PERF_W(32)) ifa ();
  pipe_ctrl_if #(.PERF_W(3))  ifb ();

  assign ifa.stallreq_id = sreq;
  assign ifa.mc_start    = start;
  assign ifa.mc_cancel   = cancel;
  assign ifa.excp_req    = excp;
  assign ifa.excp_pc     = pc;
  assign ifb.stallreq_id = sreq;
  assign ifb.mc_start    = start;
  assign ifb.mc_cancel   = cancel;
  assign ifb.excp_req    = excp;
  assign ifb.excp_pc     = pc;

  pipe_ctrl #(.MC_CYCLES(MC), .PERF_W(32)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  pipe_ctrl #(.MC_CYCLES(MC), .PERF_W(3))  dut_b (.clk(clk), .rst(rst), .bus(ifb));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Apply one cycle of inputs just after the edge, return at mid-cycle.
  task automatic drive(input logic r, input logic s, input logic st,
                       input logic c, input logic e, input logic [31:0] p);
    @(posedge clk);
    #1;
    rst = r; sreq = s; start = st; cancel = c; excp = e; pc = p;
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0);
    chk("rst_stall", ifa.stall, 0);
    chk("rst_busy", ifa.busy, 0);
    drive(1, 0, 0, 0, 0, 0);
    chk("rst_flush", ifa.flush, 0);
    chk("rst_new_pc", ifa.new_pc, 0);
    chk("rst_mc_done", ifa.mc_done, 0);
    chk("rst_cnt", ifa.stall_cycles, 0);
  endtask

  // Reference model: age = cycles since the in-flight op was issued (0 = none).
  int          age = 0;
  longint      cnt_a = 0;
  int          cnt_b = 0;
  logic [5:0]  e_stall;
  logic        e_flush, e_done, e_busy;
  logic [31:0] e_pc;

  initial begin
    @(posedge clk);
    forever begin
      int nage;
      @(negedge clk);
      e_stall = 0; e_flush = 0; e_pc = 0; e_done = 0;
      e_busy = !rst && (age > 0);
      nage = age;
      if (rst) nage = 0;
      else if (excp) begin e_flush = 1; e_pc = pc; nage = 0; end
      else if (age > 0 && cancel) begin e_stall = sreq ? 6'h07 : 6'h00; nage = 0; end
      else if (age > 0 && age < MC) begin e_stall = 6'h0F; nage = age + 1; end
      else if (age == MC) begin e_done = 1; e_stall = sreq ? 6'h07 : 6'h00; nage = 0; end
      else if (start) begin e_stall = 6'h0F; nage = 1; end
      else e_stall = sreq ? 6'h07 : 6'h00;

      chk("m_stall", ifa.stall, e_stall);
      chk("m_flush", ifa.flush, e_flush);
      chk("m_new_pc", ifa.new_pc, e_pc);
      chk("m_mc_done", ifa.mc_done, e_done);
      chk("m_busy", ifa.busy, e_busy);
      chk("m_cnt_a", ifa.stall_cycles, cnt_a);
      chk("m_stall_b", ifb.stall, e_stall);
      chk("m_cnt_b", ifb.stall_cycles, cnt_b);

      if (rst) begin cnt_a = 0; cnt_b = 0; end
      else if (e_stall[0]) begin
        if (cnt_a < 64'hFFFF_FFFF) cnt_a++;
        if (cnt_b < 7) cnt_b++;
      end
      age = nage;
    end
  end

  initial begin
    do_reset();

    // Decode stall for two cycles
    drive(0, 1, 0, 0, 0, 0); chk("t2_stall0", ifa.stall, 6'b000111);
    drive(0, 1, 0, 0, 0, 0); chk("t2_stall1", ifa.stall, 6'b000111);
    drive(0, 0, 0, 0, 0, 0); chk("t2_stall2", ifa.stall, 0);
    chk("t2_cnt", ifa.stall_cycles, 2);

    // Full multi-cycle op, decode stall in cycle 0 is overridden
    do_reset();
    drive(0, 1, 1, 0, 0, 0); chk("t3_c0_stall", ifa.stall, 6'b001111);
    chk("t3_c0_busy", ifa.busy, 0);
    for (int i = 1; i <= 3; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      chk("t3_busy_stall", ifa.stall, 6'b001111);
      chk("t3_busy", ifa.busy, 1);
      chk("t3_no_done", ifa.mc_done, 0);
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("t3_c4_done", ifa.mc_done, 1);
    chk("t3_c4_stall", ifa.stall, 0);
    chk("t3_c4_busy", ifa.busy, 1);
    drive(0, 0, 0, 0, 0, 0);
    chk("t3_c5_busy", ifa.busy, 0);
    chk("t3_c5_done", ifa.mc_done, 0);
    chk("t3_cnt", ifa.stall_cycles, 4);

    // Exception mid-op
    do_reset();
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 32'h0000_0020);
    chk("t4_flush", ifa.flush, 1);
    chk("t4_new_pc", ifa.new_pc, 32'h20);
    chk("t4_stall", ifa.stall, 0);
    for (int i = 3; i <= 5; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      chk("t4_busy", ifa.busy, 0);
      chk("t4_no_done", ifa.mc_done, 0);
    end
    drive(0, 0, 1, 0, 1, 32'h0000_0100);
    chk("t4_start_excp_flush", ifa.flush, 1);
    drive(0, 0, 0, 0, 0, 0);
    chk("t4_start_excp_busy", ifa.busy, 0);

    // Cancel mid-op
    do_reset();
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    chk("t5_stall", ifa.stall, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("t5_busy", ifa.busy, 0);
    chk("t5_cnt", ifa.stall_cycles, 2);
    drive(0, 0, 0, 0, 0, 0);
    chk("t5_no_done", ifa.mc_done, 0);

    // Counter saturation on the narrow instance
    do_reset();
    for (int i = 0; i < 10; i++) drive(0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("t6_cnt_b", ifb.stall_cycles, 7);
    chk("t6_cnt_a", ifa.stall_cycles, 10);
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("t6_cnt_b_hold", ifb.stall_cycles, 7);

    // Randomized traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      logic r, s, st, c, e;
      r  = ($urandom_range(0, 99) < 1);
      s  = ($urandom_range(0, 99) < 30);
      st = ($urandom_range(0, 99) < 20);
      c  = ($urandom_range(0, 99) < 5);
      e  = ($urandom_range(0, 99) < 3);
      drive(r, s, st, c, e, $urandom);
    end

    drive(0, 0, 0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
